fifo_arbiter: RTL and testbench

- Controller that shares the 1-bit, 4-deep shift FIFO between NUM_REQ producers and one consumer.
- Performs round-robin arbitration of push requests.
- Tracks exact occupancy, because the FIFO itself only reports non-empty.
- Issues registered push/pop/clear commands and drives the FIFO's clear after reset (the FIFO has no reset of its own).
- Sits between the microcontroller's bit producers and the FIFO instance.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/fifo_arbiter_rr_arbiter.sv | 41 ++++
 rtl/fifo_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: constants and state encoding shared by fifo_arbiter, its
// round-robin sub-arbiter and the 1-bit shift FIFO instance it controls.
package fifo_arb_pkg;

  // FIFO capacity and width of occupancy counters (must hold 0..DEPTH)
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  // Controller states: INIT clears the reset-less FIFO, FLUSH clears on request
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_arbiter_rr_arbiter.sv
// rr_arbiter: combinational request vector + pointer -> one-hot grant.
// Search starts at ptr and wraps upward. With ARB_FIXED_PRIO_EN defined the
// pointer port disappears and the block is a lowest-index priority encoder.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] cand;

  // Pick the first requester in search order
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = PTR_W'(k);
`else
      cand = PTR_W'((int'(ptr) + k) % N);
`endif
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: shares a 1-bit, DEPTH-deep shift FIFO between NUM_REQ
// producers and one consumer. Issues registered push/pop/clear commands that
// the FIFO executes one edge later, and tracks exact occupancy on both sides
// of that latency (cmd_level = committed, fifo_level = actually in the FIFO).
// Build option: ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead
// of round-robin.
module fifo_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = fifo_arb_pkg::DEPTH,
  parameter int LVL_W   = fifo_arb_pkg::LVL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0] gnt,
  input  logic               pop_req,
  output logic               rd_valid,
  output logic               rd_data,
  input  logic               flush,
  output logic               fifo_push,
  output logic               fifo_pop,
  output logic               fifo_clear,
  output logic               fifo_i,
  input  logic               fifo_p,
  input  logic               fifo_size,
  output logic [LVL_W-1:0]   level,
  output logic               full,
  output logic               empty,
  output logic               busy
);

  import fifo_arb_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_nx;
  logic [LVL_W-1:0]     cmd_level, cmd_level_nx, fifo_level;
  logic [NUM_REQ-1:0]   arb_gnt, gnt_nx;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 pop_acc, push_acc, fifo_i_nx;

`ifndef ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]     rr_ptr;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req),
`ifndef ARB_FIXED_PRIO_EN
    .ptr   (rr_ptr),
`endif
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is always assigned with <=, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  // Next-state logic: INIT and FLUSH each last exactly one cycle
  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:  state_nx = ST_RUN;
      ST_RUN:   if (flush) state_nx = ST_FLUSH;
      ST_FLUSH: state_nx = ST_RUN;
      default:  state_nx = ST_INIT;
    endcase
  end

  // Output decisions: accept pop, arbitrate push, compute committed level
  always_comb begin
    pop_acc      = 1'b0;
    push_acc     = 1'b0;
    gnt_nx       = '0;
    fifo_i_nx    = fifo_i;
    cmd_level_nx = cmd_level;
    // The RUN cycle that samples flush neither grants nor pops
    if (state == ST_RUN && !flush) begin
      pop_acc  = pop_req && rd_valid;
      // A full FIFO can still take a push when a pop is accepted alongside,
      // because the FIFO pops before it pushes
      push_acc = arb_valid && ((cmd_level < LVL_W'(DEPTH)) || pop_acc);
      if (push_acc) begin
        gnt_nx    = arb_gnt;
        fifo_i_nx = req_data[arb_idx];
      end
    end
    case ({push_acc, pop_acc})
      2'b10:   cmd_level_nx = cmd_level + LVL_W'(1);
      2'b01:   cmd_level_nx = cmd_level - LVL_W'(1);
      default: cmd_level_nx = cmd_level;
    endcase
    if (state_nx == ST_FLUSH) cmd_level_nx = '0;
  end

  // Registered FIFO commands and occupancy tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= '0;
      fifo_push  <= 1'b0;
      fifo_pop   <= 1'b0;
      fifo_clear <= 1'b1;
      fifo_i     <= 1'b0;
      cmd_level  <= '0;
      fifo_level <= '0;
    end else begin
      gnt        <= gnt_nx;
      fifo_push  <= push_acc;
      fifo_pop   <= pop_acc;
      fifo_clear <= (state_nx == ST_FLUSH);
      fifo_i     <= fifo_i_nx;
      cmd_level  <= cmd_level_nx;
      // The FIFO executes commands one edge late, so its content lags cmd_level
      fifo_level <= (state_nx == ST_FLUSH) ? '0 : cmd_level;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rr_ptr <= '0;
    else if (push_acc) rr_ptr <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
  end
`endif

  // A pop already in flight blocks the next one until the head has shifted
  assign rd_valid = (state == ST_RUN) && (fifo_level != '0) && !fifo_pop;
  assign rd_data  = fifo_p;
  assign level    = cmd_level;
  assign full     = (cmd_level == LVL_W'(DEPTH));
  assign empty    = (cmd_level == '0);
  assign busy     = (state != ST_RUN);

  // The FIFO's non-empty flag must agree with the mirrored occupancy in RUN
  a_size_consistent: assert property (@(posedge clk) disable iff (reset)
    (state == ST_RUN) |-> ((fifo_level != '0) == fifo_size));

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: self-checking bench for fifo_arbiter with a behavioural
// 1-bit, 4-deep shift FIFO (no reset, pop-before-push) attached to it.
// Expected FIFO data is queued when a grant is expected and compared on pop.
module tb_fifo_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, req_data, gnt;
  logic         pop_req, rd_valid, rd_data, flush;
  logic         fifo_push, fifo_pop, fifo_clear, fifo_i, fifo_p, fifo_size;
  logic [2:0]   level;
  logic         full, empty, busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb[$];

  always #5 clk = ~clk;

  fifo_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .pop_req    (pop_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .flush      (flush),
    .fifo_push  (fifo_push),
    .fifo_pop   (fifo_pop),
    .fifo_clear (fifo_clear),
    .fifo_i     (fifo_i),
    .fifo_p     (fifo_p),
    .fifo_size  (fifo_size),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .busy       (busy)
  );

  // FIFO model: powers up holding junk, clear wins, pop happens before push
  logic [3:0] fmem = 4'b1010;
  logic [2:0] fcnt = 3'd2;

  always @(posedge clk) begin : fifo_model
    logic [3:0] m;
    logic [2:0] c;
    m = fmem;
    c = fcnt;
    if (fifo_clear) begin
      c = 3'd0;
    end else begin
      if (fifo_pop && c != 3'd0) begin
        m = {1'b0, m[3:1]};
        c = c - 3'd1;
      end
      if (fifo_push && c < 3'd4) begin
        m[c[1:0]] = fifo_i;
        c = c + 3'd1;
      end
    end
    fmem <= m;
    fcnt <= c;
  end

  assign fifo_p    = fmem[0];
  assign fifo_size = (fcnt != 3'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Compare rd_data against the oldest expected entry
  task automatic check_head(input string tag);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else                check(tag, rd_data, sb.pop_front());
  endtask

  // Hold pop_req and drain n entries: rd_valid alternates 1,0 per pop
  task automatic drain(input string tag, input int n);
    pop_req = 1'b1;
    for (int k = 0; k < 2 * n; k++) begin
      check($sformatf("%s_vld%0d", tag, k), rd_valid, 32'((k % 2) == 0));
      if ((k % 2) == 0) check_head($sformatf("%s_data%0d", tag, k / 2));
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_end_vld%0d", tag, k), rd_valid, 0);
      check($sformatf("%s_end_pop%0d", tag, k), fifo_pop, 0);
      check($sformatf("%s_end_empty%0d", tag, k), empty, 1);
      tick();
    end
    pop_req = 1'b0;
  endtask

  // Drive held requests and expect grants in the given order, one per cycle
  task automatic push_seq(input string tag, input int ord[], input int base_lvl);
    for (int k = 0; k < ord.size(); k++) begin
      tick();
      check($sformatf("%s_gnt%0d", tag, k), gnt, 32'(1 << ord[k]));
      check($sformatf("%s_lvl%0d", tag, k), level, 32'(base_lvl + k + 1));
      sb.push_back(req_data[ord[k]]);
      req[ord[k]] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; pop_req = 1'b0; flush = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_clear", fifo_clear, 1);
    check("rst_busy",  busy, 1);
    check("rst_gnt",   gnt, 0);
    check("rst_push",  fifo_push, 0);
    check("rst_level", level, 0);
    reset = 1'b0;
    #1;
    check("init_clear", fifo_clear, 1);
    tick();
    check("run_clear", fifo_clear, 0);
    check("run_busy",  busy, 0);
    check("run_level", level, 0);
    check("run_empty", empty, 1);
    check("run_vld",   rd_valid, 0);

    // Fill with all four requesters: round-robin 0,1,2,3
    req = 4'b1111; req_data = 4'b1101;
    push_seq("fill", '{0, 1, 2, 3}, 0);
    check("fill_full", full, 1);
    req = 4'b0100; req_data[2] = 1'b0;
    tick();
    check("full_nognt0", gnt, 0);
    tick();
    check("full_nognt1", gnt, 0);
    check("full_level",  level, 4);
    check("full_vld",    rd_valid, 1);
    check("full_head",   rd_data, 1);

    // Full FIFO: pop and push in the same cycle
    pop_req = 1'b1;
    check_head("pp_data");
    tick();
    check("pp_gnt",   gnt, 32'b0100);
    check("pp_pop",   fifo_pop, 1);
    check("pp_level", level, 4);
    sb.push_back(1'b0);
    pop_req = 1'b0; req = '0;
    tick();
    drain("drain4", 4);

    // Push 1,0,1 (pointer wraps from 3 to 0), then drain with pop held
    req = 4'b0111; req_data = 4'b0101;
    push_seq("p3", '{0, 1, 2}, 0);
    repeat (2) tick();
    drain("drain3", 3);

    // Three entries then flush; requests and pop in the flush cycle are ignored
    req = 4'b1011; req_data = 4'b0110;
    push_seq("f3", '{3, 0, 1}, 0);
    repeat (2) tick();
    check("f3_level", level, 3);
    flush = 1'b1; req = 4'b1000; req_data[3] = 1'b1; pop_req = 1'b1;
    tick();
    check("fl_busy",  busy, 1);
    check("fl_clear", fifo_clear, 1);
    check("fl_level", level, 0);
    check("fl_gnt",   gnt, 0);
    check("fl_pop",   fifo_pop, 0);
    check("fl_push",  fifo_push, 0);
    check("fl_vld",   rd_valid, 0);
    sb.delete();
    flush = 1'b0; pop_req = 1'b0;
    tick();
    check("afl_busy",  busy, 0);
    check("afl_clear", fifo_clear, 0);
    check("afl_gnt",   gnt, 0);
    check("afl_level", level, 0);
    tick();
    check("afl_gnt3",  gnt, 32'b1000);
    check("afl_push",  fifo_push, 1);
    check("afl_lvl1",  level, 1);

    // Asynchronous reset while a push is in flight
    reset = 1'b1; req = '0;
    #1;
    check("ar_gnt",   gnt, 0);
    check("ar_push",  fifo_push, 0);
    check("ar_level", level, 0);
    check("ar_clear", fifo_clear, 1);
    check("ar_busy",  busy, 1);
    tick();
    reset = 1'b0;
    #1;
    check("ar_init_clear", fifo_clear, 1);
    tick();
    check("ar_run_clear", fifo_clear, 0);
    check("ar_run_busy",  busy, 0);
    check("ar_run_empty", empty, 1);
    check("ar_run_vld",   rd_valid, 0);
    repeat (2) tick();
    check("ar_still_empty", rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
